hdmi_lock_sequencer: RTL and testbench
======================================

# hdmi_lock_sequencer

Supervises the 250 MHz HDMI bit-clock PLL from the 25 MHz reference domain: holds the PLL in reset, qualifies its lock, then sweeps the PLL's 4-bit dynamic delay until the downstream TMDS decoder reports alignment. It then asserts `ready`. On loss of lock or alignment it re-sequences. It sits between the reference clock input and the PLL/TMDS capture path, driving the PLL's reset and `delay` inputs and gating the capture pipeline with `ready`.

## Interface
- `RESET_CYCLES`, 16: cycles `pll_resetb` is held low per PLL reset.
- `LOCK_STABLE`, 1024: consecutive synced-`locked` cycles required before sweeping.
- `LOCK_TIMEOUT`, 65535: max cycles in WAIT_LOCK before re-resetting the PLL.
- `SETTLE_CYCLES`, 256: wait after each `delay` change before checking.
- `CHECK_CYCLES`, 1024: consecutive `aligned` cycles required to accept a delay.
- `ALIGN_LOSS`, 16: consecutive `aligned`=0 cycles in RUN that trigger a re-sweep.
- `clock` in 1: 25 MHz reference clock, the PLL input clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `locked` in 1: PLL lock, asynchronous to `clock`.
- `aligned` in 1: decoder alignment flag, synchronous to `clock`.
- `pll_resetb` out 1: PLL RESETB, active low.
- `delay` out 4: PLL dynamic delay select.
- `ready` out 1: PLL locked and delay accepted.
- `state` out 3: current FSM state code.
- `retry_count` out 8: saturating count of re-entries into RESET_PLL.

## Operation
- `locked` passes through a 2-flop synchronizer to produce `lk`. All FSM logic uses only `lk`.
- FSM state codes: RESET_PLL=0, WAIT_LOCK=1, SETTLE=2, CHECK=3, RUN=4. Codes 5–7 are illegal and go to RESET_PLL.
- One shared cycle counter `cnt`, sized for the largest parameter. `cnt` clears on every state change.
- Separate stability counter `stab` runs in WAIT_LOCK:
  - Increments while `lk`=1; clears when `lk`=0.
  - `cnt` in WAIT_LOCK counts total time in the state.
- RESET_PLL:
  - `pll_resetb`=0, `delay`=0, `ready`=0.
  - After `RESET_CYCLES` cycles, go to WAIT_LOCK.
- WAIT_LOCK:
  - `pll_resetb`=1.
  - When `stab` reaches `LOCK_STABLE`, go to SETTLE with `delay`=0.
  - Else, when `cnt` reaches `LOCK_TIMEOUT`, go to RESET_PLL.
- SETTLE:
  - If `lk`=0, go to RESET_PLL.
  - Otherwise, after `SETTLE_CYCLES` cycles, go to CHECK.
- CHECK:
  - If `lk`=0, go to RESET_PLL.
  - If `aligned`=0 and `delay`<15: `delay`++ and go to SETTLE.
  - If `aligned`=0 and `delay`=15: go to RESET_PLL (all 16 values failed).
  - If `aligned`=1 for `CHECK_CYCLES` consecutive cycles, go to RUN.
- RUN:
  - `ready`=1 and `delay` is held.
  - If `lk`=0, go to RESET_PLL. Lock loss has priority over alignment loss.
  - If `aligned`=0 for `ALIGN_LOSS` consecutive cycles: go to SETTLE with `delay`=0 and `ready`=0.
  - Any `aligned`=1 clears the alignment-loss count.
- `retry_count` increments on every transition into RESET_PLL from another state. It saturates at 255. Entry via `reset_n` does not count.

## Timing
- Reset values while `reset_n`=0 (asynchronous): `pll_resetb`=0, `delay`=0, `ready`=0, `state`=0, `retry_count`=0, synchronizer flops=0, all counters=0.
- All outputs are registered. `state`, `ready`, `delay` and `pll_resetb` change on the same edge.
- Latency of `locked` to `lk`: 2 cycles.
  - `locked` falling in RUN drops `ready` on the 3rd rising edge after the fall, i.e. 2 sync stages plus 1 FSM edge.
- Minimum time from `reset_n` release to `ready`: `RESET_CYCLES + LOCK_STABLE + SETTLE_CYCLES + CHECK_CYCLES` cycles, plus synchronizer latency.
- `reset_n` asserted mid-sweep or in RUN returns to RESET_PLL immediately and clears `retry_count`.
- `delay` changes only on SETTLE entry. It is never modified in CHECK cycles that pass or in RUN.

## Test plan
Use `RESET_CYCLES`=4, `LOCK_STABLE`=8, `LOCK_TIMEOUT`=64, `SETTLE_CYCLES`=4, `CHECK_CYCLES`=8, `ALIGN_LOSS`=3 for all scenarios.

- Nominal bring-up: `locked`=1 from cycle 10, `aligned`=1 only when `delay`=5 → `ready`=1 with `delay`=5, `retry_count`=0.
- Lock timeout: `locked` held at 0 → `pll_resetb` pulses low for 4 cycles every 68 cycles; `retry_count` reaches 3 after 3 timeouts.
- Sweep exhaustion: `locked`=1, `aligned`=0 always → `delay` steps 0..15, then RESET_PLL, `retry_count`=1, `ready` never asserts.
- Lock loss in RUN: drop `locked` for 1 cycle → `ready`=0 on the 3rd edge, `state`=0, `retry_count` increments, `delay`=0.
- Alignment glitch vs loss in RUN:
  - `aligned`=0 for 2 cycles → `ready` stays 1.
  - `aligned`=0 for 3 cycles → `state`=2, `delay`=0, `ready`=0, `retry_count` unchanged.
- Async reset mid-CHECK with `delay`=7, `retry_count`=2 → all outputs return to reset values with no clock edge.

Source files
------------

// File: rtl/hdmi_lock_sequencer.sv
// Purpose: bring up the HDMI bit-clock PLL (reset, lock qualify, delay sweep) and flag ready.
// Latency: all outputs registered; locked -> FSM reaction is 2 sync stages + 1 FSM edge.
// Backpressure: none; a loss of lock or alignment simply restarts the relevant sequence.
module hdmi_lock_sequencer #(
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_STABLE   = 1024,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int SETTLE_CYCLES = 256,
  parameter int CHECK_CYCLES  = 1024,
  parameter int ALIGN_LOSS    = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       locked,
  input  logic       aligned,
  output logic       pll_resetb,
  output logic [3:0] delay,
  output logic       ready,
  output logic [2:0] state,
  output logic [7:0] retry_count
);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    SETTLE    = 3'd2,
    CHECK     = 3'd3,
    RUN       = 3'd4
  } state_t;

  // The shared counter must hold the largest terminal count of any state.
  localparam int M01  = (RESET_CYCLES > LOCK_STABLE) ? RESET_CYCLES : LOCK_STABLE;
  localparam int M23  = (LOCK_TIMEOUT > SETTLE_CYCLES) ? LOCK_TIMEOUT : SETTLE_CYCLES;
  localparam int M45  = (CHECK_CYCLES > ALIGN_LOSS) ? CHECK_CYCLES : ALIGN_LOSS;
  localparam int M03  = (M01 > M23) ? M01 : M23;
  localparam int MAXP = (M03 > M45) ? M03 : M45;
  localparam int CW   = $clog2(MAXP + 1);
  localparam int SW   = $clog2(LOCK_STABLE + 1);

  state_t        cur;
  state_t        nxt;
  logic [3:0]    delay_nxt;
  logic [CW-1:0] cnt;
  logic [SW-1:0] stab;
  logic          sync1;
  logic          lk;

  // Two-flop synchronizer: locked comes from the PLL, asynchronous to clock.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      lk    <= 1'b0;
    end else begin
      sync1 <= locked;
      lk    <= sync1;
    end
  end

  // Next-state and next-delay decode; every exit into RESET_PLL forces delay back to 0.
  always_comb begin
    nxt       = cur;
    delay_nxt = delay;
    case (cur)
      RESET_PLL: begin
        if (cnt == CW'(RESET_CYCLES - 1)) nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // Stability wins over the timeout when both land on the same cycle.
        if (lk && stab == SW'(LOCK_STABLE - 1)) begin
          nxt       = SETTLE;
          delay_nxt = 4'd0;
        end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
          nxt = RESET_PLL;
        end
      end
      SETTLE: begin
        if (!lk) nxt = RESET_PLL;
        else if (cnt == CW'(SETTLE_CYCLES - 1)) nxt = CHECK;
      end
      CHECK: begin
        if (!lk) begin
          nxt = RESET_PLL;
        end else if (!aligned) begin
          if (delay != 4'hF) begin
            nxt       = SETTLE;
            delay_nxt = delay + 4'd1;
          end else begin
            nxt = RESET_PLL;
          end
        end else if (cnt == CW'(CHECK_CYCLES - 1)) begin
          nxt = RUN;
        end
      end
      RUN: begin
        // In RUN, cnt counts consecutive aligned=0 cycles.
        if (!lk) begin
          nxt = RESET_PLL;
        end else if (!aligned && cnt == CW'(ALIGN_LOSS - 1)) begin
          nxt       = SETTLE;
          delay_nxt = 4'd0;
        end
      end
      default: nxt = RESET_PLL;
    endcase
    if (nxt == RESET_PLL) delay_nxt = 4'd0;
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cur <= RESET_PLL;
    else          cur <= nxt;
  end

  // Shared cycle counter (clears on any state change) and WAIT_LOCK stability counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      stab <= '0;
    end else begin
      if (nxt != cur)                  cnt <= '0;
      else if (cur == RUN && aligned)  cnt <= '0;
      else                             cnt <= cnt + 1'b1;

      if (cur == WAIT_LOCK && nxt == WAIT_LOCK && lk) stab <= stab + 1'b1;
      else                                             stab <= '0;
    end
  end

  // Registered outputs, derived from the next state so they move with the state code.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pll_resetb  <= 1'b0;
      delay       <= 4'd0;
      ready       <= 1'b0;
      retry_count <= 8'd0;
    end else begin
      pll_resetb <= (nxt != RESET_PLL);
      delay      <= delay_nxt;
      ready      <= (nxt == RUN);
      if (nxt == RESET_PLL && cur != RESET_PLL && retry_count != 8'hFF)
        retry_count <= retry_count + 8'd1;
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_hdmi_lock_sequencer.sv
// Directed bench for hdmi_lock_sequencer with small timing parameters.
// Expected output snapshots are queued when stimulus is applied and popped at sample points.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_hdmi_lock_sequencer;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       locked;
  logic       aligned;
  logic       pll_resetb;
  logic [3:0] delay;
  logic       ready;
  logic [2:0] state;
  logic [7:0] retry_count;

  logic       use_target;
  logic [3:0] target;
  logic       aligned_force;
  logic       ready_seen;

  int tests  = 0;
  int failed = 0;
  int edge_no = 0;

  typedef struct packed {
    logic [2:0] st;
    logic       rdy;
    logic [3:0] dly;
    logic       rb;
    logic [7:0] rc;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  hdmi_lock_sequencer #(
    .RESET_CYCLES (4),
    .LOCK_STABLE  (8),
    .LOCK_TIMEOUT (64),
    .SETTLE_CYCLES(4),
    .CHECK_CYCLES (8),
    .ALIGN_LOSS   (3)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .locked     (locked),
    .aligned    (aligned),
    .pll_resetb (pll_resetb),
    .delay      (delay),
    .ready      (ready),
    .state      (state),
    .retry_count(retry_count)
  );

  always #5 clock = ~clock;

  // Decoder model: either aligned only at one delay value, or a forced level.
  always_comb aligned = use_target ? (delay == target) : aligned_force;

  always @(negedge clock) if (ready) ready_seen = 1'b1;

  task automatic cmp(input string tag, input string field, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      failed++;
      $error("FAIL %s.%s observed=%0d expected=%0d", tag, field, obs, exp_v);
    end
  endtask

  task automatic expect_out(input string tag, input int st, input int rdy, input int dly, input int rb, input int rc);
    exp_t e;
    e.st  = 3'(st);
    e.rdy = 1'(rdy);
    e.dly = 4'(dly);
    e.rb  = 1'(rb);
    e.rc  = 8'(rc);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic compare_out();
    exp_t  e;
    string t;
    tests++;
    assert (exp_q.size() > 0) else begin
      failed++;
      $error("FAIL scoreboard: observed=empty expected=entry");
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      cmp(t, "state", 32'(state), 32'(e.st));
      cmp(t, "ready", 32'(ready), 32'(e.rdy));
      cmp(t, "delay", 32'(delay), 32'(e.dly));
      cmp(t, "pll_resetb", 32'(pll_resetb), 32'(e.rb));
      cmp(t, "retry_count", 32'(retry_count), 32'(e.rc));
    end
  endtask

  task automatic chk(input string tag, input int st, input int rdy, input int dly, input int rb, input int rc);
    expect_out(tag, st, rdy, dly, rb, rc);
    compare_out();
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clock);
      edge_no++;
    end
  endtask

  task automatic tick_to(input int n);
    if (n > edge_no) tick(n - edge_no);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    edge_no = 0;
  endtask

  task automatic wait_for(input string tag, input int st, input int dly, input int budget);
    int i;
    i = 0;
    while (!(state == 3'(st) && delay == 4'(dly)) && i < budget) begin
      tick(1);
      i++;
    end
    tests++;
    assert (state == 3'(st) && delay == 4'(dly)) else begin
      failed++;
      $error("FAIL %s timeout: observed state=%0d delay=%0d expected state=%0d delay=%0d",
             tag, state, delay, st, dly);
    end
  endtask

  initial begin
    reset_n       = 1'b1;
    locked        = 1'b0;
    use_target    = 1'b0;
    target        = 4'd0;
    aligned_force = 1'b0;
    ready_seen    = 1'b0;
    #1 reset_n = 1'b0;
    #1 chk("reset", 0, 0, 0, 0, 0);

    // Lock timeout: locked never rises; 4-cycle reset pulse every 68 cycles.
    do_reset();
    for (int r = 1; r <= 3; r++) begin
      tick_to(68 * r - 1);
      chk($sformatf("to%0d_wait", r), 1, 0, 0, 1, r - 1);
      tick_to(68 * r);
      chk($sformatf("to%0d_rst", r), 0, 0, 0, 0, r);
      tick_to(68 * r + 3);
      chk($sformatf("to%0d_rst_end", r), 0, 0, 0, 0, r);
      tick_to(68 * r + 4);
      chk($sformatf("to%0d_rel", r), 1, 0, 0, 1, r);
    end

    // Sweep exhaustion: lock good, never aligned.
    locked        = 1'b1;
    use_target    = 1'b0;
    aligned_force = 1'b0;
    do_reset();
    ready_seen = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tick_to(12 + 5 * k);
      chk($sformatf("sw_settle%0d", k), 2, 0, k, 1, 0);
    end
    tick_to(91);
    chk("sw_check15", 3, 0, 15, 1, 0);
    tick_to(92);
    chk("sw_exhaust", 0, 0, 0, 0, 1);
    cmp("sw", "ready_seen", 32'(ready_seen), 32'd0);

    // Nominal bring-up: lock from cycle 10, aligned only at delay 5.
    locked     = 1'b0;
    use_target = 1'b1;
    target     = 4'd5;
    do_reset();
    tick_to(10);
    locked = 1'b1;
    tick_to(12);
    chk("nom_wait", 1, 0, 0, 1, 0);
    tick_to(20);
    chk("nom_settle0", 2, 0, 0, 1, 0);
    tick_to(56);
    chk("nom_check5", 3, 0, 5, 1, 0);
    tick_to(57);
    chk("nom_run", 4, 1, 5, 1, 0);

    // Lock loss in RUN: one-cycle drop, ready falls on the 3rd edge.
    locked = 1'b0;
    expect_out("ll_edge2", 4, 1, 5, 1, 0);
    expect_out("ll_edge3", 0, 0, 0, 0, 1);
    tick(1);
    locked = 1'b1;
    tick(1);
    compare_out();
    tick(1);
    compare_out();
    wait_for("ll_recover", 4, 5, 300);
    chk("ll_run", 4, 1, 5, 1, 1);

    // Alignment glitch (2 cycles) tolerated; 3 cycles re-sweeps.
    use_target    = 1'b0;
    aligned_force = 1'b0;
    tick(2);
    aligned_force = 1'b1;
    tick(1);
    chk("glitch2", 4, 1, 5, 1, 1);
    aligned_force = 1'b0;
    expect_out("loss3_edge2", 4, 1, 5, 1, 1);
    expect_out("loss3_edge3", 2, 0, 0, 1, 1);
    tick(2);
    compare_out();
    tick(1);
    compare_out();

    // Second lock loss to reach retry_count=2, then sweep to delay 7.
    use_target = 1'b1;
    target     = 4'd7;
    locked     = 1'b0;
    expect_out("ll2_rst", 0, 0, 0, 0, 2);
    tick(1);
    locked = 1'b1;
    wait_for("ll2_wait", 0, 0, 8);
    compare_out();
    wait_for("chk7_wait", 3, 7, 300);
    chk("chk7", 3, 0, 7, 1, 2);

    // Asynchronous reset mid-CHECK, between clock edges.
    expect_out("async_rst", 0, 0, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1 compare_out();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
